// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use/redirect/memory-wait hazard controller for the 5-stage core
//
// Produces the PC and pipeline-register enables and flushes that forwarding
// cannot resolve. It also keeps a sticky data-memory wait timeout flag and
// two saturating performance counters.
//
// Ports:
//   CLK, RSTn                  clock, asynchronous active-low reset
//   rs1_id, rs2_id             source registers of the ID instruction
//   use_rs1_id, use_rs2_id     ID instruction actually reads rs1 / rs2
//   rd_ex                      destination register of the EX instruction
//   MemRead_ex, RegWrite_ex    EX instruction is a load / writes a register
//   redirect_ex                taken branch or jump resolved in EX
//   dmem_req_mem, dmem_ready   MEM data access request / completion
//   pc_write, ifid_write,
//   idex_write, exmem_write    register enables (exmem_write also gates MEM/WB)
//   ifid_flush, idex_flush     insert NOP into IF/ID, bubble into ID/EX
//   mem_timeout                sticky flag: a memory wait reached TIMEOUT cycles
//   stall_cycles, flush_count  saturating performance counters
module hazard_unit #(
  parameter int CNT_W   = 32,
  parameter int WAIT_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             MemRead_ex,
  input  logic             RegWrite_ex,
  input  logic             redirect_ex,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] TO_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              hold;
  logic              load_use;
  logic              rs1_hit;
  logic              rs2_hit;

  assign hold     = dmem_req_mem & ~dmem_ready;
  assign rs1_hit  = use_rs1_id & (rs1_id == rd_ex);
  assign rs2_hit  = use_rs2_id & (rs2_id == rd_ex);
  assign load_use = MemRead_ex & RegWrite_ex & (rd_ex != 5'd0) & (rs1_hit | rs2_hit);

  // Priority: hold freezes everything (pending redirect/load-use included),
  // a redirect kills the wrong-path ID instruction so load-use is moot.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_write  = 1'b0;
    exmem_write = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (!RSTn || hold) begin
      pc_write = 1'b0;
    end else if (redirect_ex) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (load_use) begin
      idex_write  = 1'b1;
      idex_flush  = 1'b1;
      exmem_write = 1'b1;
    end else begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
    end
  end

  // wait_cnt counts the hold cycles of the current wait already completed,
  // so the cycle that enters WAIT loads 1. The timeout fires on the hold cycle
  // that is the TIMEOUT-th in a row; in RUN wait_cnt is 0, which also covers
  // TIMEOUT == 1 on the very first hold cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state        <= ST_RUN;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hold) begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_W'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (hold) begin
            if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
          end else begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase

      if (hold && (wait_cnt == TO_LAST)) mem_timeout <= 1'b1;

      if (!pc_write && (stall_cycles != CNT_MAX)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (ifid_flush && (flush_count != CNT_MAX)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;

  localparam int CNT_W   = 4;
  localparam int WAIT_W  = 8;
  localparam int TIMEOUT = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RSTn = 1'b0;
  logic [4:0]       rs1_id = '0, rs2_id = '0, rd_ex = '0;
  logic             use_rs1_id = 0, use_rs2_id = 0, MemRead_ex = 0, RegWrite_ex = 0;
  logic             redirect_ex = 0, dmem_req_mem = 0, dmem_ready = 0;
  logic             pc_write, ifid_write, idex_write, exmem_write;
  logic             ifid_flush, idex_flush, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int tests = 0;
  int fails = 0;

  hazard_unit #(.CNT_W(CNT_W), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_ex(rd_ex), .MemRead_ex(MemRead_ex), .RegWrite_ex(RegWrite_ex),
    .redirect_ex(redirect_ex), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  int m_stall = 0;
  int m_flush = 0;
  int m_run   = 0;   // consecutive hold cycles so far
  bit m_to    = 0;

  function automatic bit m_hold();
    return dmem_req_mem && !dmem_ready;
  endfunction

  function automatic bit m_lu();
    bit hit;
    hit = (use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex);
    return MemRead_ex && RegWrite_ex && (rd_ex != 0) && hit;
  endfunction

  // {pc, ifid, idex, exmem, ifid_flush, idex_flush}
  function automatic logic [5:0] m_ctrl();
    if (!RSTn || m_hold()) return 6'b0000_00;
    if (redirect_ex)       return 6'b1111_11;
    if (m_lu())            return 6'b0011_01;
    return 6'b1111_00;
  endfunction

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_stall <= 0;
      m_flush <= 0;
      m_run   <= 0;
      m_to    <= 0;
    end else begin
      if (m_hold() || (!redirect_ex && m_lu())) m_stall <= (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (!m_hold() && redirect_ex)            m_flush <= (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (m_hold()) begin
        m_run <= m_run + 1;
        if (m_run + 1 >= TIMEOUT) m_to <= 1;
      end else begin
        m_run <= 0;
      end
    end
  end

  always @(negedge CLK) begin
    logic [5:0] act;
    act = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush};
    tests++;
    if (act !== m_ctrl() || mem_timeout !== m_to) begin
      fails++;
      $display("FAIL model_ctrl t=%0t got ctrl=%b to=%b expected ctrl=%b to=%b",
               $time, act, mem_timeout, m_ctrl(), m_to);
    end
    tests++;
    if (stall_cycles !== CNT_W'(m_stall)) begin
      fails++;
      $display("FAIL model_stall t=%0t got %0d expected %0d", $time, stall_cycles, m_stall);
    end
    tests++;
    if (flush_count !== CNT_W'(m_flush)) begin
      fails++;
      $display("FAIL model_flush t=%0t got %0d expected %0d", $time, flush_count, m_flush);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int rs1, input bit u1, input int rd, input bit ld,
                       input bit redir, input bit req, input bit rdy);
    rs1_id = 5'(rs1); use_rs1_id = u1; rs2_id = 5'd0; use_rs2_id = 1'b0;
    rd_ex = 5'(rd); MemRead_ex = ld; RegWrite_ex = ld;
    redirect_ex = redir; dmem_req_mem = req; dmem_ready = rdy;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    idle();
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_pc_write", pc_write, 0);
    chk("rst_idex_flush", idex_flush, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_timeout", mem_timeout, 0);
    tick();
    RSTn = 1'b1;
    idle();
    chk("idle_pc_write", pc_write, 1);

    // load-use: one bubble, stall counter 0 -> 1
    drive(5, 1, 5, 1, 0, 0, 1);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_ifid_write", ifid_write, 0);
    chk("lu_idex_flush", idex_flush, 1);
    chk("lu_exmem_write", exmem_write, 1);
    tick();
    idle();
    chk("lu_stall_cnt", stall_cycles, 1);
    chk("lu_after_pc_write", pc_write, 1);

    // rd_ex = 0 never stalls; rs2 path hit does
    drive(0, 1, 0, 1, 0, 0, 1);
    chk("rd0_pc_write", pc_write, 1);
    chk("rd0_idex_flush", idex_flush, 0);
    tick();
    drive(0, 0, 7, 1, 0, 0, 1);
    rs2_id = 5'd7; use_rs2_id = 1'b1; #1;
    chk("rs2_pc_write", pc_write, 0);
    tick();
    idle();
    chk("rd0_stall_cnt", stall_cycles, 2);

    // redirect together with load-use
    do_reset();
    drive(5, 1, 5, 1, 1, 0, 1);
    chk("rdlu_pc_write", pc_write, 1);
    chk("rdlu_ifid_flush", ifid_flush, 1);
    chk("rdlu_idex_flush", idex_flush, 1);
    tick();
    idle();
    chk("rdlu_flush_cnt", flush_count, 1);
    chk("rdlu_stall_cnt", stall_cycles, 0);

    // 3-cycle memory wait
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("wait_pc_write", pc_write, 0);
      chk("wait_exmem_write", exmem_write, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("wait_done_pc_write", pc_write, 1);
    tick();
    idle();
    chk("wait_stall_cnt", stall_cycles, 3);
    chk("wait_timeout", mem_timeout, 0);

    // redirect deferred by a 2-cycle wait
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 1, 1, 0);
      chk("defer_no_flush", ifid_flush, 0);
      tick();
    end
    drive(0, 0, 0, 0, 1, 1, 1);
    chk("defer_flush", ifid_flush, 1);
    tick();
    idle();
    chk("defer_flush_cnt", flush_count, 1);
    chk("defer_stall_cnt", stall_cycles, 2);

    // timeout at the 4th hold edge, sticky, then reset mid-wait
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      tick();
      if (i == 3) chk("to_after3", mem_timeout, 0);
      if (i == 4) chk("to_after4", mem_timeout, 1);
    end
    chk("to_still_set", mem_timeout, 1);
    #2;
    RSTn = 1'b0;
    #1;
    chk("midrst_timeout", mem_timeout, 0);
    chk("midrst_stall", stall_cycles, 0);
    chk("midrst_pc_write", pc_write, 0);
    chk("midrst_exmem_write", exmem_write, 0);
    tick();
    RSTn = 1'b1;
    idle();
    chk("postrst_pc_write", pc_write, 1);
    tick();

    // counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(3, 1, 3, 1, 0, 0, 1);
      tick();
    end
    idle();
    chk("sat_stall", stall_cycles, CMAX);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 1, 0, 1);
      tick();
    end
    idle();
    chk("sat_flush", flush_count, CMAX);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core. It produces the stall, bubble and flush controls that the forwarding logic cannot resolve: load-use stalls, taken-branch/jump flushes and data-memory wait freezes. It also owns a data-memory wait timeout and saturating performance counters. It sits beside the forwarding unit and drives the write-enable and flush inputs of the PC and of the IF/ID, ID/EX and EX/MEM pipeline registers.

## Interface
Parameters:
- CNT_W, 32: width of the performance counters.
- WAIT_W, 8: width of the memory-wait counter.
- TIMEOUT, 255: number of consecutive wait cycles that sets mem_timeout. Must satisfy 1 ≤ TIMEOUT ≤ 2^WAIT_W−1.

Ports:
- CLK, input, 1: the single clock; all state updates on the rising edge.
- RSTn, input, 1: asynchronous, active-low reset.
- rs1_id, input, 5: rs1 of the instruction in ID.
- rs2_id, input, 5: rs2 of the instruction in ID.
- use_rs1_id, input, 1: the ID instruction reads rs1.
- use_rs2_id, input, 1: the ID instruction reads rs2.
- rd_ex, input, 5: destination register of the instruction in EX.
- MemRead_ex, input, 1: the EX instruction is a load.
- RegWrite_ex, input, 1: the EX instruction writes a register.
- redirect_ex, input, 1: taken branch or jump resolved in EX.
- dmem_req_mem, input, 1: the MEM instruction accesses data memory.
- dmem_ready, input, 1: data memory completes the access this cycle.
- pc_write, output, 1: PC register enable.
- ifid_write, output, 1: IF/ID register enable.
- idex_write, output, 1: ID/EX register enable.
- exmem_write, output, 1: EX/MEM register enable; the same signal also gates MEM/WB.
- ifid_flush, output, 1: load a NOP into IF/ID.
- idex_flush, output, 1: load a bubble into ID/EX (all control bits 0).
- mem_timeout, output, 1: sticky error flag.
- stall_cycles, output, CNT_W: count of cycles in which pc_write was 0.
- flush_count, output, CNT_W: count of cycles in which a redirect flush was applied.

## Operation
Internal conditions:
- hold = dmem_req_mem & ~dmem_ready.
- load_use = MemRead_ex & RegWrite_ex & (rd_ex≠0) & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex)).

Controls are combinational from the inputs, with priority hold > redirect_ex > load_use:
- hold: every write enable is 0 and both flushes are 0. The whole pipeline freezes, including a pending redirect or load-use.
- redirect_ex (without hold): all write enables are 1, ifid_flush=1 and idex_flush=1. load_use is ignored because the ID instruction is on the wrong path.
- load_use (without hold or redirect): pc_write=0, ifid_write=0, idex_write=1, idex_flush=1, exmem_write=1. This produces exactly one bubble.
- otherwise: all write enables are 1 and both flushes are 0.

The FSM has two states, RUN and WAIT:
- RUN→WAIT when hold. WAIT→RUN when ~hold. WAIT stays in WAIT while hold.
- wait_cnt is cleared on entry to RUN. In WAIT it increments each cycle and saturates at 2^WAIT_W−1.
- mem_timeout is set when the FSM is in WAIT, hold is asserted and wait_cnt==TIMEOUT−1. It stays set until reset. The pipeline continues to wait after it is set.

Counters:
- stall_cycles increments on every cycle in which pc_write==0 (hold or load_use).
- flush_count increments on every cycle in which ifid_flush==1.
- Both counters saturate at all-ones and never wrap.

## Timing
Reset (RSTn low, asynchronous):
- State goes to RUN; wait_cnt, stall_cycles, flush_count and mem_timeout go to 0.
- While RSTn is low, all write enables are forced to 0 and both flushes to 0.
- Deassertion is synchronised externally. The first rising edge with RSTn high evaluates normally.

Latency and hold behaviour:
- Control outputs have zero-cycle latency, in the same cycle as the inputs.
- A load-use stall lasts exactly 1 cycle, because on the next cycle the load has moved to MEM.
- A redirect flush lasts exactly 1 cycle. If redirect_ex arrives during hold, the flush is applied on the first cycle after dmem_ready.
- An access that completes in the same cycle it is issued (dmem_ready=1) causes no hold and the FSM stays in RUN.
- A wait of N cycles freezes the pipeline for exactly N cycles.

Timeout and counters:
- mem_timeout first reads 1 on the output at the edge after TIMEOUT consecutive hold cycles.
- Counter values update on the edge after the qualifying cycle.
- Reset asserted mid-wait aborts the wait immediately: outputs go to the reset values and the FSM returns to RUN.

## Test plan
- Load-use: lw x5 in EX with rd_ex=5, MemRead_ex=1, RegWrite_ex=1; ID has use_rs1_id=1, rs1_id=5. Required: pc_write=0, ifid_write=0, idex_flush=1 for 1 cycle; stall_cycles goes 0→1.
- rd_ex=0 guard: same stimulus with rd_ex=rs1_id=0. Required: no stall, all enables 1.
- Redirect during load-use: redirect_ex=1 together with load_use. Required: ifid_flush=idex_flush=1, pc_write=1; flush_count=1, stall_cycles=0.
- Memory wait: dmem_req_mem=1, dmem_ready=0 for 3 cycles, then 1. Required: all enables 0 for exactly 3 cycles, FSM in WAIT, stall_cycles=3, mem_timeout=0.
- Redirect deferred by hold: redirect_ex=1 held throughout a 2-cycle wait. Required: no flush during the wait; flush on the cycle dmem_ready=1; flush_count=1.
- Timeout and reset: TIMEOUT=4, hold for 6 cycles. Required: mem_timeout=1 after the 4th edge. RSTn pulsed low mid-wait: mem_timeout=0, counters 0, enables 0 while RSTn is low.
